// File: rtl/serial_add_ctrl_if.sv
// rtl/serial_add_ctrl_if.sv - request/result bundle for the bit-serial adder sequencer
// SERIAL_ADD_SUB_EN adds the sub select to the bundle.
interface serial_add_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Cin;
  logic             busy;
  logic             done;
  logic             ack;
  logic [WIDTH-1:0] S;
  logic             Cout;
`ifdef SERIAL_ADD_SUB_EN
  logic             sub;
`endif

  modport master (
`ifdef SERIAL_ADD_SUB_EN
    output sub,
`endif
    output start, A, B, Cin, ack,
    input  busy, done, S, Cout
  );

  modport slave (
`ifdef SERIAL_ADD_SUB_EN
    input  sub,
`endif
    input  start, A, B, Cin, ack,
    output busy, done, S, Cout
  );
endinterface

// File: rtl/serial_add_ctrl.sv
// rtl/serial_add_ctrl.sv - one full-adder cell time-shared over WIDTH cycles, LSB first
// SERIAL_ADD_SUB_EN enables A-B via inverted B and forced carry-in.
module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input logic             clk,
  input logic             reset,
  serial_add_ctrl_if.slave bus
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-2:0] res_sh;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             busy_r;
  logic             done_r;
  logic [WIDTH-1:0] s_r;
  logic             cout_r;

  logic             fa_s;
  logic             fa_c;
  logic [WIDTH-1:0] res_next;
  logic [WIDTH-1:0] b_load;
  logic             c_load;

  assign fa_s     = a_sh[0] ^ b_sh[0] ^ carry;
  assign fa_c     = (a_sh[0] & b_sh[0]) | (carry & (a_sh[0] ^ b_sh[0]));
  // res_sh keeps the WIDTH-1 sums collected so far; the newest sum completes the word
  assign res_next = {fa_s, res_sh};

`ifdef SERIAL_ADD_SUB_EN
  assign b_load = bus.sub ? ~bus.B : bus.B;
  assign c_load = bus.sub | bus.Cin;
`else
  assign b_load = bus.B;
  assign c_load = bus.Cin;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      a_sh   <= '0;
      b_sh   <= '0;
      res_sh <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      busy_r <= 1'b0;
      done_r <= 1'b0;
      s_r    <= '0;
      cout_r <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            state  <= RUN;
            a_sh   <= bus.A;
            b_sh   <= b_load;
            carry  <= c_load;
            cnt    <= '0;
            res_sh <= '0;
            busy_r <= 1'b1;
          end
        end
        RUN: begin
          a_sh   <= a_sh >> 1;
          b_sh   <= b_sh >> 1;
          res_sh <= res_next[WIDTH-1:1];
          carry  <= fa_c;
          cnt    <= cnt + 1'b1;
          if (cnt == LAST) begin
            state  <= DONE;
            s_r    <= res_next;
            cout_r <= fa_c;
            done_r <= 1'b1;
          end
        end
        DONE: begin
          // a start arriving with ack is dropped; the requester re-asserts it
          if (bus.ack) begin
            state  <= IDLE;
            busy_r <= 1'b0;
            done_r <= 1'b0;
          end
        end
        default: begin
          state  <= IDLE;
          busy_r <= 1'b0;
          done_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy = busy_r;
  assign bus.done = done_r;
  assign bus.S    = s_r;
  assign bus.Cout = cout_r;
endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb/tb_serial_add_ctrl.sv - vector table, corner sequences and random ops against an arithmetic model
// Builds with or without SERIAL_ADD_SUB_EN.
module tb_serial_add_ctrl;
  localparam int W = 8;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  serial_add_ctrl_if #(.WIDTH(W)) bus ();
  serial_add_ctrl #(.WIDTH(W)) dut (.clk(clk), .reset(reset), .bus(bus));

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sb;
    logic [W-1:0] s;
    logic         cout;
  } vec_t;

  vec_t vecs[$];
  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // sum/difference from plain integer arithmetic
  function automatic logic [W:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                       input logic cin, input logic sb);
    int unsigned ai, bi, r;
    ai = a;
    bi = b;
    if (sb) begin
      r = (ai + (1 << W) - bi) % (1 << W);
      return {(ai >= bi), r[W-1:0]};
    end
    r = ai + bi + cin;
    return r[W:0];
  endfunction

  task automatic drive_start(input logic [W-1:0] a, input logic [W-1:0] b,
                             input logic cin, input logic sb);
    bus.A = a;
    bus.B = b;
    bus.Cin = cin;
`ifdef SERIAL_ADD_SUB_EN
    bus.sub = sb;
`else
    if (sb) $display("note: sub request ignored in add-only build");
`endif
    bus.start = 1'b1;
  endtask

  // called at a negedge in IDLE; returns at the negedge where done is seen (or timeout)
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                        input logic sb, input bit inject, output int lat,
                        output logic busy_ok, output logic hold_ok);
    logic [W-1:0] s0;
    logic         c0;
    s0 = bus.S;
    c0 = bus.Cout;
    drive_start(a, b, cin, sb);
    @(negedge clk);
    bus.start = 1'b0;
    lat = 1;
    busy_ok = 1'b1;
    hold_ok = 1'b1;
    while (bus.done !== 1'b1 && lat < 40) begin
      if (bus.busy !== 1'b1) busy_ok = 1'b0;
      if (bus.S !== s0 || bus.Cout !== c0) hold_ok = 1'b0;
      if (inject && lat == 3) begin
        bus.A = 8'h11;
        bus.B = 8'h11;
        bus.start = 1'b1;
      end else begin
        bus.start = 1'b0;
      end
      @(negedge clk);
      lat++;
    end
    bus.start = 1'b0;
    if (bus.busy !== 1'b1) busy_ok = 1'b0;
  endtask

  task automatic ack_done(input string tag);
    bus.ack = 1'b1;
    @(negedge clk);
    bus.ack = 1'b0;
    chk({tag, "_done_after_ack"}, bus.done, 1'b0);
    chk({tag, "_busy_after_ack"}, bus.busy, 1'b0);
  endtask

  task automatic op_check(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic cin, input logic sb, input bit inject);
    int lat;
    logic bok, hok;
    logic [W:0] exp;
    exp = model(a, b, cin, sb);
    run_op(a, b, cin, sb, inject, lat, bok, hok);
    chk({tag, "_latency"}, lat, W + 1);
    chk({tag, "_S"}, bus.S, exp[W-1:0]);
    chk({tag, "_Cout"}, bus.Cout, exp[W]);
    chk({tag, "_busy_run"}, bok, 1'b1);
    chk({tag, "_hold"}, hok, 1'b1);
  endtask

  initial begin
    int lat;
    logic bok, hok;
    logic [W-1:0] s_keep;

    reset = 1'b1;
    bus.start = 1'b0;
    bus.ack = 1'b0;
    bus.A = '0;
    bus.B = '0;
    bus.Cin = 1'b0;
`ifdef SERIAL_ADD_SUB_EN
    bus.sub = 1'b0;
`endif

    vecs.push_back('{8'h5A, 8'h3C, 1'b0, 1'b0, 8'h96, 1'b0});
    vecs.push_back('{8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1});
    vecs.push_back('{8'h00, 8'h00, 1'b1, 1'b0, 8'h01, 1'b0});
    vecs.push_back('{8'hFF, 8'hFF, 1'b1, 1'b0, 8'hFF, 1'b1});
    vecs.push_back('{8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1});
    vecs.push_back('{8'h0F, 8'hF0, 1'b1, 1'b0, 8'h00, 1'b1});
`ifdef SERIAL_ADD_SUB_EN
    vecs.push_back('{8'h10, 8'h01, 1'b0, 1'b1, 8'h0F, 1'b1});
    vecs.push_back('{8'h01, 8'h02, 1'b1, 1'b1, 8'hFF, 1'b0});
    vecs.push_back('{8'h33, 8'h33, 1'b0, 1'b1, 8'h00, 1'b1});
`endif

    #12;
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_done", bus.done, 1'b0);
    chk("rst_S", bus.S, 8'h00);
    chk("rst_Cout", bus.Cout, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    foreach (vecs[i]) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sb, 1'b0, lat, bok, hok);
      chk($sformatf("vec%0d_latency", i), lat, W + 1);
      chk($sformatf("vec%0d_S", i), bus.S, vecs[i].s);
      chk($sformatf("vec%0d_Cout", i), bus.Cout, vecs[i].cout);
      chk($sformatf("vec%0d_busy_run", i), bok, 1'b1);
      chk($sformatf("vec%0d_hold", i), hok, 1'b1);
      ack_done($sformatf("vec%0d", i));
    end

    // start re-pulsed mid-RUN must be ignored
    op_check("midrun_start", 8'h5A, 8'h3C, 1'b0, 1'b0, 1'b1);
    chk("midrun_S_fixed", bus.S, 8'h96);
    ack_done("midrun");

    // async reset during RUN discards the operation
    drive_start(8'h77, 8'h11, 1'b0, 1'b0);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("async_rst_busy", bus.busy, 1'b0);
    chk("async_rst_done", bus.done, 1'b0);
    chk("async_rst_S", bus.S, 8'h00);
    chk("async_rst_Cout", bus.Cout, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    chk("post_rst_no_done", bus.done, 1'b0);
    op_check("post_rst", 8'hA5, 8'h5B, 1'b1, 1'b0, 1'b0);
    ack_done("post_rst");

    // ack and start together in DONE: ack wins, start dropped; idle ack ignored
    run_op(8'h21, 8'h43, 1'b0, 1'b0, 1'b0, lat, bok, hok);
    chk("ackstart_pre_done", bus.done, 1'b1);
    s_keep = bus.S;
    bus.ack = 1'b1;
    drive_start(8'h01, 8'h01, 1'b0, 1'b0);
    @(negedge clk);
    bus.start = 1'b0;
    chk("ackstart_done", bus.done, 1'b0);
    chk("ackstart_busy", bus.busy, 1'b0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("idle_ack%0d_busy", k), bus.busy, 1'b0);
      chk($sformatf("idle_ack%0d_done", k), bus.done, 1'b0);
      chk($sformatf("idle_ack%0d_S", k), bus.S, s_keep);
    end
    bus.ack = 1'b0;
    @(negedge clk);

    for (int r = 0; r < 40; r++) begin
      logic sb;
`ifdef SERIAL_ADD_SUB_EN
      sb = 1'($urandom_range(0, 1));
`else
      sb = 1'b0;
`endif
      op_check($sformatf("rand%0d", r), W'($urandom), W'($urandom), 1'($urandom), sb, 1'b0);
      ack_done($sformatf("rand%0d", r));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
